// File: rtl/fir_ctrl_pkg.sv
// Shared types and sizing helpers for the FIR coefficient controller and the FIR wrapper.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SWAP  = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Pipeline stages the systolic FIR adds on top of one stage per tap.
  localparam int FIR_PIPE_EXTRA = 6;

  function automatic int coef_idx_w(input int filt_depth);
    return (filt_depth / 2 > 1) ? $clog2(filt_depth / 2) : 1;
  endfunction

  function automatic int pipe_latency(input int filt_depth);
    return filt_depth + FIR_PIPE_EXTRA;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient storage: beats land in the shadow bank, a swap copies it
// wholesale into the active bank that feeds the FIR.
module fir_coef_bank import fir_ctrl_pkg::*; #(
  parameter int COEF_WIDTH = 16,
  parameter int NUM_COEF   = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           wr_en_i,
  input  logic [ADDR_W-1:0]              wr_addr_i,
  input  logic [COEF_WIDTH-1:0]          wr_data_i,
  input  logic                           swap_i,
  output logic [NUM_COEF*COEF_WIDTH-1:0] coef_o,
  output logic                           all_written_o
);

  logic [COEF_WIDTH-1:0] shadow_q [NUM_COEF];
  logic [COEF_WIDTH-1:0] active_q [NUM_COEF];
  logic [NUM_COEF-1:0]   written_q;
  logic [NUM_COEF-1:0]   written_d;
  logic [NUM_COEF-1:0]   wr_onehot;

  always_comb begin
    wr_onehot = '0;
    if (wr_en_i) wr_onehot[wr_addr_i] = 1'b1;
  end

  // Counts the beat being written this cycle, so a commit beat can complete the set.
  assign all_written_o = &(written_q | wr_onehot);

  always_comb begin
    written_d = written_q | wr_onehot;
    if (swap_i) written_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int h = 0; h < NUM_COEF; h++) begin
        shadow_q[h] <= '0;
        active_q[h] <= '0;
      end
      written_q <= '0;
    end else begin
      written_q <= written_d;
      if (wr_en_i) shadow_q[wr_addr_i] <= wr_data_i;
      if (swap_i) begin
        for (int h = 0; h < NUM_COEF; h++) active_q[h] <= shadow_q[h];
      end
    end
  end

  for (genvar h = 0; h < NUM_COEF; h++) begin : g_flat
    assign coef_o[h*COEF_WIDTH +: COEF_WIDTH] = active_q[h];
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Runtime coefficient controller: atomic shadow->active commit and output-valid masking
// for one full FIR pipeline latency after each swap.
module fir_coef_ctrl import fir_ctrl_pkg::*; #(
  parameter int COEF_WIDTH    = 16,
  parameter int FILT_DEPTH    = 64,
  parameter int OUTDATA_WIDTH = 16,
  parameter int PIPE_LATENCY  = pipe_latency(FILT_DEPTH)
) (
  input  logic                                    clk_main,
  input  logic                                    rst_n,
  // Config port: a beat transfers on a rising edge where cfg_vld and cfg_rdy are both high;
  // the requester holds cfg_addr/cfg_data/cfg_last stable while cfg_vld waits for cfg_rdy.
  input  logic                                    cfg_vld,
  output logic                                    cfg_rdy,
  input  logic [coef_idx_w(FILT_DEPTH)-1:0]       cfg_addr,
  input  logic [COEF_WIDTH-1:0]                   cfg_data,
  input  logic                                    cfg_last,
  output logic                                    cfg_err,
  output logic [(FILT_DEPTH/2)*COEF_WIDTH-1:0]    coef_out,
  output logic [7:0]                              coef_gen,
  input  logic                                    fir_vld_in,
  input  logic [OUTDATA_WIDTH-1:0]                fir_data_in,
  output logic                                    m_vld,
  output logic [OUTDATA_WIDTH-1:0]                m_data,
  output logic                                    busy,
  output state_t                                  dbg_state
);

  localparam int NUM_COEF = FILT_DEPTH / 2;
  localparam int ADDR_W   = coef_idx_w(FILT_DEPTH);
  localparam int CNT_W    = $clog2(PIPE_LATENCY + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(PIPE_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] blank_cnt_q;
  logic [7:0]       coef_gen_q;
  logic             cfg_err_q;
  logic             cfg_fire;
  logic             all_written;

  assign cfg_rdy  = (state_q == RUN);
  assign cfg_fire = cfg_vld & cfg_rdy;

  fir_coef_bank #(
    .COEF_WIDTH (COEF_WIDTH),
    .NUM_COEF   (NUM_COEF),
    .ADDR_W     (ADDR_W)
  ) u_bank (
    .clk_i         (clk_main),
    .rst_ni        (rst_n),
    .wr_en_i       (cfg_fire),
    .wr_addr_i     (cfg_addr),
    .wr_data_i     (cfg_data),
    .swap_i        (state_q == SWAP),
    .coef_o        (coef_out),
    .all_written_o (all_written)
  );

  // The blanking counter counts clocks, not samples: the FIR shifts every cycle.
  always_ff @(posedge clk_main) begin
    if (!rst_n) begin
      state_q     <= RUN;
      blank_cnt_q <= '0;
      coef_gen_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (cfg_fire && cfg_last) begin
            if (all_written) state_q   <= SWAP;
            else             cfg_err_q <= 1'b1;
          end
        end
        SWAP: begin
          coef_gen_q  <= coef_gen_q + 8'd1;
          blank_cnt_q <= BLANK_LOAD;
          state_q     <= BLANK;
        end
        BLANK: begin
          blank_cnt_q <= blank_cnt_q - CNT_ONE;
          if (blank_cnt_q == CNT_ONE) state_q <= RUN;
        end
        default: begin
          state_q     <= RUN;
          blank_cnt_q <= '0;
        end
      endcase
    end
  end

  assign cfg_err   = cfg_err_q;
  assign coef_gen  = coef_gen_q;
  assign busy      = (state_q != RUN);
  assign m_vld     = fir_vld_in & (state_q == RUN);
  assign m_data    = fir_data_in;
  assign dbg_state = state_q;

endmodule

// File: doc/fir_coef_ctrl.md
# fir_coef_ctrl

Runtime coefficient controller for the symmetric 7-DSP48 systolic FIR. It accepts coefficient writes over a valid/ready config port into a shadow bank and commits them atomically into the active bank that drives the filter's coefficient inputs. After each swap it masks the filter's output-valid for one full pipeline latency, so no output mixes old and new coefficients. It sits between the config/control plane and the FIR instance. Filter data passes through unmodified.

## Interface
Parameters:
- COEF_WIDTH, 16, width of one coefficient (signed)
- FILT_DEPTH, 64, filter taps; FILT_DEPTH/2 unique coefficients
- OUTDATA_WIDTH, 16, FIR output width
- PIPE_LATENCY, FILT_DEPTH+6, FIR input-valid to output-valid latency in cycles

Ports:
- clk_main  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- cfg_vld  in  1  config beat valid
- cfg_rdy  out  1  config beat ready
- cfg_addr  in  $clog2(FILT_DEPTH/2)  coefficient index
- cfg_data  in  COEF_WIDTH  coefficient value
- cfg_last  in  1  commit request, qualified by the handshake
- cfg_err  out  1  one-cycle pulse: commit rejected
- coef_out  out  FILT_DEPTH/2*COEF_WIDTH  active bank, flattened; index h at bits [h*COEF_WIDTH +: COEF_WIDTH]
- coef_gen  out  8  active-bank generation, increments per successful swap, wraps 255→0
- fir_vld_in  in  1  FIR outdata_vld
- fir_data_in  in  OUTDATA_WIDTH  FIR data_out
- m_vld  out  1  gated output valid
- m_data  out  OUTDATA_WIDTH  equal to fir_data_in (combinational pass-through)
- busy  out  1  high in SWAP or BLANK

## Operation
- States:
  - RUN: cfg_rdy=1; accepted beats write shadow[cfg_addr] and set written[cfg_addr].
  - SWAP: lasts 1 cycle.
  - BLANK: lasts PIPE_LATENCY cycles.
- Commit: an accepted beat with cfg_last=1 writes its own data first, then evaluates completeness, including that beat's address.
  - All FILT_DEPTH/2 written bits set: go to SWAP.
  - Otherwise: pulse cfg_err, stay in RUN, keep shadow and written mask unchanged.
- SWAP:
  - Copy active←shadow, clear written mask, coef_gen+1.
  - Load blank_cnt=PIPE_LATENCY, go to BLANK.
- BLANK:
  - blank_cnt decrements each cycle; at the edge where blank_cnt==1, go to RUN.
  - Counts cycles, not samples: the FIR shifts every clock regardless of valid.
- m_vld = fir_vld_in & (state==RUN). cfg_rdy = (state==RUN).
- Rewriting an address before commit: the last value wins.
- cfg_vld during SWAP or BLANK: not accepted and not lost; the requester holds the beat.
- Reset, including mid-BLANK or mid-load:
  - shadow, active, written mask, coef_gen, blank_cnt all cleared; state=RUN.
  - Outputs: cfg_rdy=1, cfg_err=0, busy=0, m_vld=0 when fir_vld_in=0, coef_out=0.
  - A reset during BLANK drops the mask immediately; the integration owns resetting the FIR's valid chain alongside.

## Timing
- Write: beat accepted at edge T means shadow is updated at T.
- Commit accepted at edge T:
  - SWAP during cycle T→T+1.
  - coef_out and coef_gen show new values after edge T+1.
  - BLANK occupies cycles T+1 … T+PIPE_LATENCY.
  - RUN resumes after edge T+1+PIPE_LATENCY.
- Mask window: m_vld=0 for PIPE_LATENCY+1 consecutive cycles (SWAP + BLANK).
- cfg_err asserts in cycle T→T+1 only.
- cfg_rdy drops the cycle after the commit edge. Max busy time between commits is PIPE_LATENCY+1 cycles.
- m_data and m_vld have zero added latency (combinational from fir_*_in and state).

## Structure
- Package fir_ctrl_pkg:
  - state enum {RUN, SWAP, BLANK}
  - localparam function coef_idx_w(FILT_DEPTH) = $clog2(FILT_DEPTH/2)
  - default PIPE_LATENCY expression shared with the FIR wrapper
- Sub-module fir_coef_bank holds the shadow array, written mask, active array, flatten logic, and all_written flag. Its controls are wr_en, wr_addr, wr_data, and swap.
- Top level holds the FSM, blank_cnt (width $clog2(PIPE_LATENCY+1)), coef_gen and valid gating.

## Test plan
- Full load and swap:
  - Stimulus: write idx h = h+1 for h=0..31, with cfg_last on h=31, then commit.
  - Response: coef_out[h]=h+1 one cycle after the commit cycle; coef_gen=1; m_vld=0 for exactly 71 cycles with fir_vld_in held at 1; busy for 71 cycles.
- Incomplete commit:
  - Stimulus: write idx 0..30, then commit on idx 5.
  - Response: cfg_err pulses once; coef_out unchanged; written mask retained. A subsequent write to idx 31 with cfg_last swaps successfully.
- Back-pressure:
  - Stimulus: drive cfg_vld continuously during BLANK.
  - Response: cfg_rdy=0 and no shadow change; the held beat is accepted on the first RUN cycle.
- Overwrite:
  - Stimulus: write idx 3 = 0x1234, then 0xBEEF, then complete and commit.
  - Response: coef_out[3]=0xBEEF.
- Reset mid-BLANK:
  - Stimulus: assert rst_n=0 for 1 cycle at BLANK cycle 20.
  - Response: state RUN, coef_out=0, coef_gen=0, cfg_rdy=1 next cycle.
- Generation wrap:
  - Stimulus: perform 256 successful swaps.
  - Response: coef_gen returns to 0.
